// File: rtl/mem_block_arbiter.sv
// mem_block_arbiter
// Shares the single block-wide backing-memory port between the I-cache refill path and the
// D-cache refill/write-back path. A D-side write-back followed by a refill runs as one
// operation. FREEZE stalls the pipeline while any block request is held.
//
// Optional feature macro: ARB_RR_EN
//   defined   -> round-robin tie-break between I and D using a last-grant register
//   undefined -> fixed priority, D wins a tie
//
// Ports:
//   CLK, RESET                 clock (rising edge), asynchronous active-low reset
//   i_blk_req/addr             I-side block read request (level) and miss address
//   i_blk_done/data            I completion pulse and registered refill block
//   d_blk_read/write           D-side read / write-back requests (level)
//   d_blk_addr, d_wb_addr      D-side refill and victim addresses
//   d_blk_wdata                write-back block
//   d_blk_done/data            D completion pulse and registered refill block
//   mem_req/we/addr/wdata      registered memory transaction outputs
//   mem_rdata, mem_ready       memory read data and one-cycle completion pulse
//   FREEZE                     combinational pipeline stall
//   grant                      01 = I owns port, 10 = D owns port, 00 = idle
module mem_block_arbiter #(
  parameter int unsigned BLK_W  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_blk_req,
  input  logic [ADDR_W-1:0] i_blk_addr,
  output logic              i_blk_done,
  output logic [BLK_W-1:0]  i_blk_data,
  input  logic              d_blk_read,
  input  logic              d_blk_write,
  input  logic [ADDR_W-1:0] d_blk_addr,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [BLK_W-1:0]  d_blk_wdata,
  output logic              d_blk_done,
  output logic [BLK_W-1:0]  d_blk_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_ready,
  output logic              FREEZE,
  output logic [1:0]        grant
);

  typedef enum logic [2:0] {StIdle, StIRd, StDWb, StDRd, StDone} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BLK_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [BLK_W-1:0]    i_data_q, i_data_d;
  logic [BLK_W-1:0]    d_data_q, d_data_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic [1:0]          grant_q, grant_d;
  // Latched at grant time so a write-back knows whether a refill follows.
  logic                rd_after_wb_q, rd_after_wb_d;
  logic                d_pending, pick_d, pick_i;
`ifdef ARB_RR_EN
  logic                last_d_q, last_d_d;  // 1 = D was granted last, 0 = I
`endif

  function automatic logic [ADDR_W-1:0] blk_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:5], 5'b0};
  endfunction

  assign d_pending = d_blk_read | d_blk_write;
  assign FREEZE    = i_blk_req | d_pending;

  always_comb begin
`ifdef ARB_RR_EN
    // On a tie, grant the side that was not granted last.
    if (i_blk_req && d_pending) pick_d = ~last_d_q;
    else                        pick_d = d_pending;
`else
    pick_d = d_pending;
`endif
    pick_i = i_blk_req & ~pick_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    i_data_d      = i_data_q;
    d_data_d      = d_data_q;
    i_done_d      = 1'b0;
    d_done_d      = 1'b0;
    grant_d       = grant_q;
    rd_after_wb_d = rd_after_wb_q;
`ifdef ARB_RR_EN
    last_d_d      = last_d_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_d) begin
          mem_req_d     = 1'b1;
          grant_d       = 2'b10;
          rd_after_wb_d = d_blk_read;
`ifdef ARB_RR_EN
          last_d_d      = 1'b1;
`endif
          if (d_blk_write) begin
            state_d     = StDWb;
            mem_we_d    = 1'b1;
            mem_addr_d  = blk_align(d_wb_addr);
            mem_wdata_d = d_blk_wdata;
          end else begin
            state_d    = StDRd;
            mem_we_d   = 1'b0;
            mem_addr_d = blk_align(d_blk_addr);
          end
        end else if (pick_i) begin
          state_d    = StIRd;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = blk_align(i_blk_addr);
          grant_d    = 2'b01;
`ifdef ARB_RR_EN
          last_d_d   = 1'b0;
`endif
        end
      end
      StIRd: begin
        if (mem_req_q && mem_ready) begin
          i_data_d  = mem_rdata;
          i_done_d  = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          grant_d   = 2'b00;
          state_d   = StDone;
        end
      end
      StDWb: begin
        if (mem_req_q && mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (rd_after_wb_q) begin
            // Refill follows directly; mem_req reasserts one cycle later in StDRd.
            state_d    = StDRd;
            mem_addr_d = blk_align(d_blk_addr);
          end else begin
            d_done_d = 1'b1;
            grant_d  = 2'b00;
            state_d  = StDone;
          end
        end
      end
      StDRd: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;  // gap cycle after a write-back
        end else if (mem_ready) begin
          d_data_d  = mem_rdata;
          d_done_d  = 1'b1;
          mem_req_d = 1'b0;
          grant_d   = 2'b00;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= StIdle;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      i_data_q      <= '0;
      d_data_q      <= '0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      grant_q       <= 2'b00;
      rd_after_wb_q <= 1'b0;
`ifdef ARB_RR_EN
      last_d_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      i_data_q      <= i_data_d;
      d_data_q      <= d_data_d;
      i_done_q      <= i_done_d;
      d_done_q      <= d_done_d;
      grant_q       <= grant_d;
      rd_after_wb_q <= rd_after_wb_d;
`ifdef ARB_RR_EN
      last_d_q      <= last_d_d;
`endif
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign i_blk_data = i_data_q;
  assign d_blk_data = d_data_q;
  assign i_blk_done = i_done_q;
  assign d_blk_done = d_done_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed bench for mem_block_arbiter. Inputs are driven and outputs sampled on the falling
// clock edge, away from the rising edge where the DUT updates.
module tb_mem_block_arbiter;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         i_blk_req;
  logic [31:0]  i_blk_addr;
  logic         i_blk_done;
  logic [255:0] i_blk_data;
  logic         d_blk_read;
  logic         d_blk_write;
  logic [31:0]  d_blk_addr;
  logic [31:0]  d_wb_addr;
  logic [255:0] d_blk_wdata;
  logic         d_blk_done;
  logic [255:0] d_blk_data;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ready;
  logic         FREEZE;
  logic [1:0]   grant;

  int tests = 0;
  int fails = 0;

  logic [255:0] pat_a5;
  logic [255:0] pat_wb;
  logic [255:0] pat_rd;
  logic [255:0] pat_i2;
  logic [1:0]   exp_grant;

  always #5 CLK = ~CLK;

  mem_block_arbiter dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_blk_req  (i_blk_req),
    .i_blk_addr (i_blk_addr),
    .i_blk_done (i_blk_done),
    .i_blk_data (i_blk_data),
    .d_blk_read (d_blk_read),
    .d_blk_write(d_blk_write),
    .d_blk_addr (d_blk_addr),
    .d_wb_addr  (d_wb_addr),
    .d_blk_wdata(d_blk_wdata),
    .d_blk_done (d_blk_done),
    .d_blk_data (d_blk_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .FREEZE     (FREEZE),
    .grant      (grant)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_wb = {8{32'hDEAD_BEEF}};
    pat_rd = {8{32'h0123_4567}};
    pat_i2 = {8{32'h7777_1111}};
    RESET = 1'b0;
    i_blk_req = 1'b0; i_blk_addr = '0;
    d_blk_read = 1'b0; d_blk_write = 1'b0;
    d_blk_addr = '0; d_wb_addr = '0; d_blk_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    // Reset values
    cyc(); cyc();
    check("rst_mem_req", mem_req, 0);
    check("rst_grant", grant, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_i_data", i_blk_data, 0);
    check("rst_freeze", FREEZE, 0);
    RESET = 1'b1;
    cyc();

    // I-only read, mem_ready three cycles after mem_req
    i_blk_req = 1'b1; i_blk_addr = 32'h0040_0024;
    #1 check("i_freeze_req_cycle", FREEZE, 1);
    cyc();
    check("i_mem_req", mem_req, 1);
    check("i_mem_we", mem_we, 0);
    check("i_mem_addr", mem_addr, 32'h0040_0020);
    check("i_grant", grant, 2'b01);
    cyc(); cyc();
    check("i_no_done_early", i_blk_done, 0);
    cyc();
    mem_ready = 1'b1; mem_rdata = pat_a5;
    cyc();
    mem_ready = 1'b0; mem_rdata = '0;
    check("i_done", i_blk_done, 1);
    check("i_data", i_blk_data, pat_a5);
    check("i_done_mem_req", mem_req, 0);
    check("i_freeze_held", FREEZE, 1);
    cyc();
    check("i_done_one_cycle", i_blk_done, 0);
    check("i_data_held", i_blk_data, pat_a5);
    i_blk_req = 1'b0;
    #1 check("i_freeze_drop", FREEZE, 0);
    cyc();
    check("i_idle_mem_req", mem_req, 0);
    check("i_idle_grant", grant, 0);

    // Simultaneous I and D reads, four rounds
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_RR_EN
      exp_grant = (r % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_grant = 2'b10;
`endif
      i_blk_req = 1'b1; i_blk_addr = 32'h0000_2000 + 32'(r * 32);
      d_blk_read = 1'b1; d_blk_addr = 32'h2000_0000 + 32'(r * 32);
      cyc();
      check($sformatf("tie%0d_grant", r), grant, exp_grant);
      check($sformatf("tie%0d_addr", r), mem_addr,
            exp_grant[1] ? 32'h2000_0000 + 32'(r * 32) : 32'h0000_2000 + 32'(r * 32));
      mem_ready = 1'b1; mem_rdata = pat_i2 ^ 256'(r);
      cyc();
      mem_ready = 1'b0;
      check($sformatf("tie%0d_d_done", r), d_blk_done, exp_grant[1]);
      check($sformatf("tie%0d_i_done", r), i_blk_done, exp_grant[0]);
      cyc();
      i_blk_req = 1'b0; d_blk_read = 1'b0;
      cyc();
    end

    // D write-back followed by refill
    d_blk_write = 1'b1; d_blk_read = 1'b1;
    d_wb_addr = 32'h1000_0040; d_blk_addr = 32'h1000_0080; d_blk_wdata = pat_wb;
    cyc();
    check("wb_mem_req", mem_req, 1);
    check("wb_mem_we", mem_we, 1);
    check("wb_mem_addr", mem_addr, 32'h1000_0040);
    check("wb_mem_wdata", mem_wdata, pat_wb);
    check("wb_grant", grant, 2'b10);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    check("wb_gap_mem_req", mem_req, 0);
    check("wb_gap_no_done", d_blk_done, 0);
    check("wb_gap_grant", grant, 2'b10);
    cyc();
    check("rd_mem_req", mem_req, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 32'h1000_0080);
    mem_ready = 1'b1; mem_rdata = pat_rd;
    cyc();
    mem_ready = 1'b0;
    check("rd_done", d_blk_done, 1);
    check("rd_data", d_blk_data, pat_rd);
    cyc();
    check("rd_done_once", d_blk_done, 0);
    d_blk_write = 1'b0; d_blk_read = 1'b0;
    cyc();

    // Stray mem_ready in IDLE, then minimum latency
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    check("stray_mem_req", mem_req, 0);
    check("stray_i_done", i_blk_done, 0);
    check("stray_d_done", d_blk_done, 0);
    check("stray_grant", grant, 0);
    i_blk_req = 1'b1; i_blk_addr = 32'h0000_0100;
    cyc();
    check("min_mem_req", mem_req, 1);
    mem_ready = 1'b1; mem_rdata = pat_i2;
    cyc();
    mem_ready = 1'b0;
    check("min_done_2cyc", i_blk_done, 1);
    check("min_data", i_blk_data, pat_i2);
    cyc();
    i_blk_req = 1'b0;
    cyc();

    // Reset asserted during D_RD
    d_blk_read = 1'b1; d_blk_addr = 32'h3000_0020;
    cyc();
    check("rst_drd_mem_req", mem_req, 1);
    check("rst_drd_grant", grant, 2'b10);
    RESET = 1'b0;
    cyc();
    check("rst_abort_mem_req", mem_req, 0);
    check("rst_abort_grant", grant, 0);
    check("rst_abort_no_done", d_blk_done, 0);
    check("rst_abort_d_data", d_blk_data, 0);
    d_blk_read = 1'b0;
    RESET = 1'b1;
    cyc();
    i_blk_req = 1'b1; i_blk_addr = 32'h0000_1234;
    cyc();
    check("post_rst_mem_addr", mem_addr, 32'h0000_1220);
    check("post_rst_grant", grant, 2'b01);
    mem_ready = 1'b1; mem_rdata = pat_a5;
    cyc();
    mem_ready = 1'b0;
    check("post_rst_done", i_blk_done, 1);
    check("post_rst_data", i_blk_data, pat_a5);
    cyc();
    i_blk_req = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
